// File: rtl/soc_pkg.sv
// rtl/soc_pkg.sv - shared SoC types and constants for the memory port arbiter
package soc_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CPU  = 2'd1,
    ARB_GFX  = 2'd2
  } arb_state_t;

  localparam logic [31:0] SOC_GFX_BASE = 32'h0100_0000;

endpackage

// File: rtl/gfx_mem_adapter.sv
// rtl/gfx_mem_adapter.sv - maps Graphite halfword accesses onto the 32-bit cache port
module gfx_mem_adapter
  import soc_pkg::*;
#(
  parameter logic [31:0] GFX_BASE = SOC_GFX_BASE
) (
  input  logic [31:0] gfx_addr_i,
  input  logic        gfx_wr_i,
  input  logic [15:0] gfx_wdata_i,
  input  logic [31:0] mem_dout_i,
  output logic [25:0] mem_addr_o,
  output logic [3:0]  mem_wmask_o,
  output logic [31:0] mem_din_o,
  output logic [15:0] gfx_rdata_o
);

  logic [25:0] word_off;
  logic        unused_addr_bits;

  // Only the low 26 bits of the sum survive, so higher halfword bits cannot matter.
  assign word_off         = {gfx_addr_i[24:1], 2'b00};
  assign mem_addr_o       = GFX_BASE[25:0] + word_off;
  assign unused_addr_bits = ^gfx_addr_i[31:25];

  assign mem_wmask_o = gfx_wr_i ? (gfx_addr_i[0] ? 4'b1100 : 4'b0011) : 4'b0000;
  assign mem_din_o   = {gfx_wdata_i, gfx_wdata_i};
  assign gfx_rdata_o = gfx_addr_i[0] ? mem_dout_i[31:16] : mem_dout_i[15:0];

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - weighted CPU/Graphite arbiter in front of the cache controller
module mem_port_arbiter
  import soc_pkg::*;
#(
  parameter logic [31:0] GFX_BASE  = SOC_GFX_BASE,
  parameter int          GFX_BURST = 8
) (
  input  logic        clk_cpu,
  input  logic        rst_n,
  input  logic        cpu_sel_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [3:0]  cpu_wmask_i,
  input  logic [31:0] cpu_wdata_i,
  output logic        cpu_ack_o,
  output logic [31:0] cpu_rdata_o,
  input  logic        gfx_sel_i,
  input  logic        gfx_wr_i,
  input  logic [31:0] gfx_addr_i,
  input  logic [15:0] gfx_wdata_i,
  output logic        gfx_ack_o,
  output logic [15:0] gfx_rdata_o,
  output logic        mem_mreq_o,
  output logic [25:0] mem_addr_o,
  output logic [3:0]  mem_wmask_o,
  output logic [31:0] mem_din_o,
  input  logic        mem_rdy_i,
  input  logic [31:0] mem_dout_i
);

  localparam logic [7:0] GFX_LAST = 8'(GFX_BURST - 1);

  arb_state_t  state_q, state_d;
  logic [7:0]  gfx_cnt_q, gfx_cnt_d;
  logic        cpu_own, gfx_own, cpu_done, gfx_done;
  logic [25:0] gfx_addr;
  logic [3:0]  gfx_wmask;
  logic [31:0] gfx_din;
  logic        unused_cpu_addr;

  gfx_mem_adapter #(
    .GFX_BASE(GFX_BASE)
  ) u_gfx_adapter (
    .gfx_addr_i (gfx_addr_i),
    .gfx_wr_i   (gfx_wr_i),
    .gfx_wdata_i(gfx_wdata_i),
    .mem_dout_i (mem_dout_i),
    .mem_addr_o (gfx_addr),
    .mem_wmask_o(gfx_wmask),
    .mem_din_o  (gfx_din),
    .gfx_rdata_o(gfx_rdata_o)
  );

  // Ownership is masked by rst_n so nothing leaks out while reset is held.
  assign cpu_own  = rst_n && (state_q == ARB_CPU);
  assign gfx_own  = rst_n && (state_q == ARB_GFX);
  assign cpu_done = cpu_own && cpu_sel_i && mem_rdy_i;
  assign gfx_done = gfx_own && gfx_sel_i && mem_rdy_i;

  assign cpu_ack_o       = cpu_done;
  assign gfx_ack_o       = gfx_done;
  assign cpu_rdata_o     = mem_dout_i;
  assign unused_cpu_addr = ^cpu_addr_i[31:26];

  always_comb begin
    mem_mreq_o  = 1'b0;
    mem_addr_o  = 26'd0;
    mem_wmask_o = 4'b0000;
    mem_din_o   = 32'd0;
    if (cpu_own) begin
      mem_mreq_o  = cpu_sel_i;
      mem_addr_o  = cpu_addr_i[25:0];
      mem_wmask_o = cpu_we_i ? cpu_wmask_i : 4'b0000;
      mem_din_o   = cpu_wdata_i;
    end else if (gfx_own) begin
      mem_mreq_o  = gfx_sel_i;
      mem_addr_o  = gfx_addr;
      mem_wmask_o = gfx_wmask;
      mem_din_o   = gfx_din;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (cpu_sel_i)      state_d = ARB_CPU;
        else if (gfx_sel_i) state_d = ARB_GFX;
      end
      ARB_CPU: begin
        if (gfx_sel_i && (cpu_done || !cpu_sel_i)) state_d = ARB_GFX;
      end
      ARB_GFX: begin
        if (cpu_sel_i && (!gfx_sel_i || (gfx_done && gfx_cnt_q == GFX_LAST)))
          state_d = ARB_CPU;
      end
      default: state_d = ARB_IDLE;
    endcase

    // Counter only measures Graphite runs while the CPU is actually waiting.
    gfx_cnt_d = gfx_cnt_q;
    if (!cpu_sel_i || (state_d == ARB_CPU && state_q != ARB_CPU))
      gfx_cnt_d = 8'd0;
    else if (gfx_done)
      gfx_cnt_d = gfx_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_cpu) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      gfx_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      gfx_cnt_q <= gfx_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int BURST = 8;

  logic        clk_cpu = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_sel = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [3:0]  cpu_wmask = '0;
  logic        cpu_ack_o;
  logic [31:0] cpu_rdata_o;
  logic        gfx_sel = 1'b0, gfx_wr = 1'b0;
  logic [31:0] gfx_addr = '0;
  logic [15:0] gfx_wdata = '0;
  logic        gfx_ack_o;
  logic [15:0] gfx_rdata_o;
  logic        mem_mreq_o;
  logic [25:0] mem_addr_o;
  logic [3:0]  mem_wmask_o;
  logic [31:0] mem_din_o;
  logic        mem_rdy = 1'b0;
  logic [31:0] mem_dout = '0;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the port (0 none, 1 cpu, 2 gfx) and burst count.
  int m_own = 0;
  int m_cnt = 0;
  logic e_cpu_ack, e_gfx_ack;
  logic o_cpu_ack, o_gfx_ack, o_mreq;
  logic [25:0] o_addr;
  logic [3:0]  o_wmask;
  logic [31:0] o_din;

  always #5 clk_cpu = ~clk_cpu;

  mem_port_arbiter dut (
    .clk_cpu    (clk_cpu),
    .rst_n      (rst_n),
    .cpu_sel_i  (cpu_sel),
    .cpu_we_i   (cpu_we),
    .cpu_addr_i (cpu_addr),
    .cpu_wmask_i(cpu_wmask),
    .cpu_wdata_i(cpu_wdata),
    .cpu_ack_o  (cpu_ack_o),
    .cpu_rdata_o(cpu_rdata_o),
    .gfx_sel_i  (gfx_sel),
    .gfx_wr_i   (gfx_wr),
    .gfx_addr_i (gfx_addr),
    .gfx_wdata_i(gfx_wdata),
    .gfx_ack_o  (gfx_ack_o),
    .gfx_rdata_o(gfx_rdata_o),
    .mem_mreq_o (mem_mreq_o),
    .mem_addr_o (mem_addr_o),
    .mem_wmask_o(mem_wmask_o),
    .mem_din_o  (mem_din_o),
    .mem_rdy_i  (mem_rdy),
    .mem_dout_i (mem_dout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [25:0] gfx_word_addr(input logic [31:0] a);
    logic [31:0] t;
    t = 32'h0100_0000 + ((a >> 1) & 32'h3FFF_FFFF) * 4;
    return t[25:0];
  endfunction

  // One clock: compare outputs against the model, advance the model, step the clock.
  task automatic cyc();
    logic        e_mreq;
    logic [25:0] e_addr;
    logic [3:0]  e_wmask;
    logic [31:0] e_din;
    int          old_own;
    #1;
    e_mreq = 1'b0; e_addr = '0; e_wmask = '0; e_din = '0;
    if (rst_n && m_own == 1) begin
      e_mreq = cpu_sel; e_addr = cpu_addr[25:0];
      e_wmask = cpu_we ? cpu_wmask : 4'h0; e_din = cpu_wdata;
    end else if (rst_n && m_own == 2) begin
      e_mreq = gfx_sel; e_addr = gfx_word_addr(gfx_addr);
      e_wmask = gfx_wr ? (gfx_addr[0] ? 4'hC : 4'h3) : 4'h0;
      e_din = {gfx_wdata, gfx_wdata};
    end
    e_cpu_ack = rst_n && m_own == 1 && cpu_sel && mem_rdy;
    e_gfx_ack = rst_n && m_own == 2 && gfx_sel && mem_rdy;
    o_cpu_ack = cpu_ack_o; o_gfx_ack = gfx_ack_o; o_mreq = mem_mreq_o;
    o_addr = mem_addr_o; o_wmask = mem_wmask_o; o_din = mem_din_o;
    chk("mreq", 32'(mem_mreq_o), 32'(e_mreq));
    chk("wmask", 32'(mem_wmask_o), 32'(e_wmask));
    chk("cpu_ack", 32'(cpu_ack_o), 32'(e_cpu_ack));
    chk("gfx_ack", 32'(gfx_ack_o), 32'(e_gfx_ack));
    chk("cpu_rdata", cpu_rdata_o, mem_dout);
    chk("gfx_rdata", 32'(gfx_rdata_o), 32'(gfx_addr[0] ? mem_dout[31:16] : mem_dout[15:0]));
    chk("gfx_cnt", 32'(dut.gfx_cnt_q), 32'(m_cnt));
    if (e_mreq) begin
      chk("addr", 32'(mem_addr_o), 32'(e_addr));
      chk("din", mem_din_o, e_din);
    end
    old_own = m_own;
    if (!rst_n) begin
      m_own = 0; m_cnt = 0;
    end else begin
      if (m_own == 0) m_own = cpu_sel ? 1 : (gfx_sel ? 2 : 0);
      else if (m_own == 1 && gfx_sel && (e_cpu_ack || !cpu_sel)) m_own = 2;
      else if (m_own == 2 && cpu_sel && (!gfx_sel || (e_gfx_ack && m_cnt == BURST - 1))) m_own = 1;
      if (!cpu_sel || (m_own == 1 && old_own != 1)) m_cnt = 0;
      else if (e_gfx_ack) m_cnt = m_cnt + 1;
    end
    @(posedge clk_cpu);
    #1;
  endtask

  logic        cpu_hold, gfx_hold;
  logic [25:0] held_addr;

  initial begin
    @(posedge clk_cpu);
    #1;
    // Reset with both requesters active; then weighted pattern 1 CPU : 8 GFX.
    rst_n = 1'b0; cpu_sel = 1'b1; gfx_sel = 1'b1; mem_rdy = 1'b1;
    cpu_we = 1'b1; cpu_wmask = 4'hF; cpu_addr = 32'h0000_1230; cpu_wdata = 32'h1111_2222;
    gfx_addr = 32'h0000_0002; gfx_wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_mreq", 32'(o_mreq), 32'd0);
      chk("rst_acks", 32'({o_cpu_ack, o_gfx_ack}), 32'd0);
    end
    rst_n = 1'b1;
    cyc();
    chk("post_rst_idle", 32'({o_mreq, o_wmask, o_cpu_ack, o_gfx_ack}), 32'd0);
    for (int i = 0; i < 27; i++) begin
      cyc();
      chk("weight_pattern", 32'({o_cpu_ack, o_gfx_ack}), (i % 9 == 0) ? 32'd2 : 32'd1);
    end

    // Graphite halfword write to the upper lane.
    rst_n = 1'b0; cpu_sel = 1'b0; gfx_sel = 1'b0;
    cyc();
    rst_n = 1'b1; gfx_sel = 1'b1; gfx_wr = 1'b1;
    gfx_addr = 32'h0000_0005; gfx_wdata = 16'hABCD;
    cyc();
    cyc();
    chk("gfx_wr_addr", 32'(o_addr), 32'h0100_0008);
    chk("gfx_wr_mask", 32'(o_wmask), 32'hC);
    chk("gfx_wr_din", o_din, 32'hABCD_ABCD);
    chk("gfx_wr_ack", 32'(o_gfx_ack), 32'd1);

    // CPU stalled while Graphite starts requesting.
    rst_n = 1'b0; gfx_sel = 1'b0;
    cyc();
    rst_n = 1'b1; cpu_sel = 1'b1; mem_rdy = 1'b0; cpu_addr = 32'hFFC0_0444;
    cyc();
    cyc();
    held_addr = o_addr;
    gfx_sel = 1'b1; gfx_wr = 1'b0; gfx_addr = 32'h0000_0010;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_hold", 32'({o_mreq, o_gfx_ack, o_cpu_ack}), 32'b100);
      chk("stall_addr", 32'(o_addr), 32'(held_addr));
    end
    mem_rdy = 1'b1;
    cyc();
    chk("stall_done", 32'(o_cpu_ack), 32'd1);
    cpu_sel = 1'b0;
    cyc();
    chk("stall_handover", 32'(o_gfx_ack), 32'd1);

    // Graphite alone: back-to-back acks, counter stays cleared.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    for (int i = 0; i < 20; i++) begin
      gfx_addr = 32'(i);
      cyc();
      chk("park_ack", 32'(o_gfx_ack), 32'd1);
      chk("park_cnt", 32'(dut.gfx_cnt_q), 32'd0);
    end

    // Reset in the middle of a stalled Graphite access.
    mem_rdy = 1'b0;
    cyc();
    rst_n = 1'b0; mem_rdy = 1'b1;
    cyc();
    chk("midrst_noack", 32'({o_cpu_ack, o_gfx_ack}), 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("midrst_idle", 32'(o_gfx_ack), 32'd0);
    cyc();
    chk("midrst_regrant", 32'(o_gfx_ack), 32'd1);

    // Randomized traffic; requests stay stable until acknowledged.
    cpu_hold = 1'b0; gfx_hold = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (!cpu_hold) begin
        cpu_sel = ($urandom % 3) != 0; cpu_we = 1'($urandom);
        cpu_addr = $urandom; cpu_wmask = 4'($urandom); cpu_wdata = $urandom;
      end
      if (!gfx_hold) begin
        gfx_sel = ($urandom % 3) != 0; gfx_wr = 1'($urandom);
        gfx_addr = $urandom; gfx_wdata = 16'($urandom);
      end
      mem_rdy = ($urandom % 4) != 0;
      mem_dout = $urandom;
      rst_n = ($urandom % 97) != 0;
      cyc();
      cpu_hold = cpu_sel && !e_cpu_ack;
      gfx_hold = gfx_sel && !e_gfx_ack;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
